// File: rtl/phy_rx.sv
// Serial receive half of the PHY link: deserialises the MSB-first line stream,
// aligns on COMMA symbols and delivers payload bytes with a valid flag.
module phy_rx #(
  parameter int unsigned       WIDTH    = 8,
  parameter logic [WIDTH-1:0]  COMMA    = WIDTH'(8'hBC),
  parameter logic [WIDTH-1:0]  IDLE     = WIDTH'(8'h7C),
  parameter int unsigned       BC_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             active
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned BC_W  = $clog2(BC_COUNT + 1);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_ALIGN  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [CNT_W-1:0] w_bit_cnt_nxt;
  logic [BC_W-1:0]  r_bc_cnt;
  logic [BC_W-1:0]  w_bc_cnt_nxt;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] w_data_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_active;
  logic             w_active_nxt;
  logic             w_last_bit;
  logic             w_is_comma;
  logic             w_is_idle;

  // Symbol window including the bit sampled on this edge.
  assign w_shift_nxt = {r_shift[WIDTH-2:0], data_in};
  assign w_last_bit  = (r_bit_cnt == CNT_W'(WIDTH - 1));
  assign w_is_comma  = (w_shift_nxt == COMMA);
  assign w_is_idle   = (w_shift_nxt == IDLE);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_state <= S_SEARCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_bc_cnt  <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_active  <= 1'b0;
    end else begin
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_bc_cnt  <= w_bc_cnt_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_active  <= w_active_nxt;
    end
  end

  // Next-state and next-output logic; decisions in ALIGN/ACTIVE happen on symbol LSBs only.
  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = w_last_bit ? '0 : r_bit_cnt + CNT_W'(1);
    w_bc_cnt_nxt  = r_bc_cnt;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_active_nxt  = r_active;

    case (r_state)
      S_SEARCH: begin
        w_bit_cnt_nxt = '0;
        if (w_is_comma) begin
          w_bc_cnt_nxt = BC_W'(1);
          if (BC_COUNT <= 1) begin
            w_state_nxt  = S_ACTIVE;
            w_active_nxt = 1'b1;
          end else begin
            w_state_nxt = S_ALIGN;
          end
        end
      end

      S_ALIGN: begin
        if (w_last_bit) begin
          if (w_is_comma) begin
            w_bc_cnt_nxt = r_bc_cnt + BC_W'(1);
            if (r_bc_cnt == BC_W'(BC_COUNT - 1)) begin
              w_state_nxt  = S_ACTIVE;
              w_active_nxt = 1'b1;
            end
          end else begin
            w_state_nxt  = S_SEARCH;
            w_bc_cnt_nxt = '0;
          end
        end
      end

      S_ACTIVE: begin
        w_active_nxt = 1'b1;
        if (w_last_bit) begin
          if (w_is_comma || w_is_idle) begin
            w_valid_nxt = 1'b0;
          end else begin
            w_data_nxt  = w_shift_nxt;
            w_valid_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = S_SEARCH;
      end
    endcase
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign active    = r_active;

endmodule

// File: tb/tb_phy_rx.sv
// Bench for phy_rx: directed symbol tables, hand-written corner sequences and
// randomized streams checked bit-by-bit against a symbol-level reference model.
module tb_phy_rx;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_IDLE  = 8'h7C;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic [7:0] data_out1;
  logic       valid_out1;
  logic       active1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_32f = ~clk_32f;

  phy_rx #(.WIDTH(8), .COMMA(8'hBC), .IDLE(8'h7C), .BC_COUNT(4)) u_dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active)
  );

  // Single-comma build, fed the same line.
  phy_rx #(.WIDTH(8), .COMMA(8'hBC), .IDLE(8'h7C), .BC_COUNT(1)) u_dut1 (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out1),
    .valid_out (valid_out1),
    .active    (active1)
  );

  // Reference model: tracks bits since alignment and judges whole symbols.
  int         m_win;
  int         m_since;
  int         m_commas;
  bit         m_hunting;
  bit         m_act;
  bit         m_vld;
  logic [7:0] m_dout;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_win     = 0;
    m_since   = 0;
    m_commas  = 0;
    m_hunting = 1'b1;
    m_act     = 1'b0;
    m_vld     = 1'b0;
    m_dout    = 8'h00;
  endtask

  task automatic model_bit(input bit b);
    m_win = ((m_win << 1) | int'(b)) & 255;
    if (m_hunting) begin
      if (m_win == int'(K_COMMA)) begin
        m_hunting = 1'b0;
        m_since   = 0;
        m_commas  = 1;
      end
    end else begin
      m_since++;
      if (m_since % 8 == 0) begin
        if (!m_act) begin
          if (m_win == int'(K_COMMA)) begin
            m_commas++;
            if (m_commas == 4) m_act = 1'b1;
          end else begin
            m_hunting = 1'b1;
            m_commas  = 0;
          end
        end else if (m_win == int'(K_COMMA) || m_win == int'(K_IDLE)) begin
          m_vld = 1'b0;
        end else begin
          m_vld  = 1'b1;
          m_dout = 8'(m_win);
        end
      end
    end
  endtask

  task automatic send_bit(input bit b);
    @(negedge clk_32f);
    data_in = b;
    @(posedge clk_32f);
    #1;
    model_bit(b);
    check("model_active", 32'(active), 32'(m_act));
    check("model_valid", 32'(valid_out), 32'(m_vld));
    check("model_data", 32'(data_out), 32'(m_dout));
  endtask

  task automatic send_sym(input logic [7:0] s);
    for (int i = 7; i >= 0; i--) send_bit(s[i]);
  endtask

  // Asserts reset between edges, checks the asynchronous clear, releases before the next falling edge.
  task automatic do_reset();
    #1;
    reset = 1'b0;
    #1;
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(valid_out), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_active1", 32'(active1), 32'h0);
    model_reset();
    @(posedge clk_32f);
    #2;
    reset = 1'b1;
  endtask

  typedef struct {
    logic [7:0] sym;
    logic       exp_act;
    logic       exp_vld;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;
    model_reset();

    // Preamble, first payload, then payload with fillers between.
    tbl[0] = '{8'hBC, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{8'hBC, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{8'hBC, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{8'hBC, 1'b1, 1'b0, 8'h00};
    tbl[4] = '{8'hA5, 1'b1, 1'b1, 8'hA5};
    tbl[5] = '{8'h12, 1'b1, 1'b1, 8'h12};
    tbl[6] = '{8'h7C, 1'b1, 1'b0, 8'h12};
    tbl[7] = '{8'hBC, 1'b1, 1'b0, 8'h12};
    tbl[8] = '{8'h34, 1'b1, 1'b1, 8'h34};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      send_sym(tbl[i].sym);
      check("tbl_active", 32'(active), 32'(tbl[i].exp_act));
      check("tbl_valid", 32'(valid_out), 32'(tbl[i].exp_vld));
      check("tbl_data", 32'(data_out), 32'(tbl[i].exp_data));
    end

    // Offset start: three junk bits before the preamble.
    do_reset();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 4; i++) send_sym(K_COMMA);
    check("offset_active", 32'(active), 32'h1);
    send_sym(8'h3C);
    check("offset_data", 32'(data_out), 32'h3C);
    check("offset_valid", 32'(valid_out), 32'h1);

    // Broken preamble restarts the comma count at one.
    do_reset();
    send_sym(K_COMMA); send_sym(K_COMMA); send_sym(8'h55); send_sym(K_COMMA);
    check("broken_active0", 32'(active), 32'h0);
    send_sym(K_COMMA); send_sym(K_COMMA);
    check("broken_active1", 32'(active), 32'h0);
    send_sym(K_COMMA);
    check("broken_active2", 32'(active), 32'h1);

    // Reset in the middle of a payload byte.
    do_reset();
    for (int i = 0; i < 4; i++) send_sym(K_COMMA);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    do_reset();
    send_sym(8'h99);
    check("midrst_valid", 32'(valid_out), 32'h0);
    check("midrst_active", 32'(active), 32'h0);
    for (int i = 0; i < 4; i++) send_sym(K_COMMA);
    check("midrst_realign", 32'(active), 32'h1);
    send_sym(8'h99);
    check("midrst_data", 32'(data_out), 32'h99);
    check("midrst_dvalid", 32'(valid_out), 32'h1);

    // Single-comma build.
    do_reset();
    send_sym(K_COMMA);
    check("bc1_active", 32'(active1), 32'h1);
    send_sym(8'hF0);
    check("bc1_data", 32'(data_out1), 32'hF0);
    check("bc1_valid", 32'(valid_out1), 32'h1);

    // Randomized streams with junk prefixes, broken preambles and bit slips.
    for (int it = 0; it < 20; it++) begin
      do_reset();
      for (int j = 0; j < int'($urandom_range(0, 7)); j++) send_bit(1'($urandom));
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 9) == 0) send_sym(8'($urandom));
        send_sym(K_COMMA);
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int c = 0; c < 4; c++) send_sym(K_COMMA);
      end
      for (int s = 0; s < 24; s++) begin
        case ($urandom_range(0, 3))
          0:       send_sym(K_COMMA);
          1:       send_sym(K_IDLE);
          default: send_sym(8'($urandom));
        endcase
        if ($urandom_range(0, 15) == 0) send_bit(1'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
